// File: rtl/falcon_pkg.sv
// Shared constants, FSM encoding and degree derivation for the small-polynomial
// Gaussian coefficient generator.
package falcon_pkg;

   localparam int unsigned LOGN_DEF  = 9;
   localparam int unsigned BOUND_DEF = 127;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

   function automatic int unsigned poly_n(input int unsigned logn);
      return 32'd1 << logn;
   endfunction

endpackage

// File: rtl/coef_check.sv
// Combinational acceptance test for one Gaussian sample: magnitude bound plus the
// odd-total-parity rule applied to the final coefficient.
module coef_check
   import falcon_pkg::*;
#(
   parameter int unsigned BOUND = BOUND_DEF
) (
   input  logic [31:0] val_i,
   input  logic        last_i,
   input  logic        mod2_i,
   output logic        accept_o
);

   localparam logic signed [31:0] BoundHi = $signed(32'(BOUND));
   localparam logic signed [31:0] BoundLo = -BoundHi;

   logic in_range;
   logic parity_bad;

   always_comb begin
      // Full-width signed compare so large values with small low bytes are rejected.
      in_range   = ($signed(val_i) >= BoundLo) && ($signed(val_i) <= BoundHi);
      parity_bad = last_i && !(mod2_i ^ val_i[0]);
      accept_o   = in_range && !parity_bad;
   end

endmodule

// File: rtl/poly_small_mkgauss.sv
// Collects N bounded Gaussian samples from an upstream sampler and writes them as
// 8-bit coefficients, forcing odd total parity and counting rejected samples.
module poly_small_mkgauss
   import falcon_pkg::*;
#(
   parameter int unsigned LOGN  = LOGN_DEF,
   parameter int unsigned BOUND = BOUND_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        gauss_ena,
   input  logic        val_valid,
   input  logic [31:0] val,
   output logic        coef_we,
   output logic [9:0]  coef_addr,
   output logic [7:0]  coef_data,
   output logic        busy,
   output logic        done,
   output logic [15:0] rej_cnt
);

   localparam int unsigned N     = poly_n(LOGN);
   localparam logic [9:0]  ULast = 10'(N - 1);

   state_e      state_q, state_d;
   logic [9:0]  u_q, u_d;
   logic        mod2_q, mod2_d;
   logic [15:0] rej_q, rej_d;
   logic        we_q, we_d;
   logic [9:0]  addr_q, addr_d;
   logic [7:0]  data_q, data_d;
   logic        done_q, done_d;

   logic last;
   logic accept;

   assign last = (u_q == ULast);

   coef_check #(
      .BOUND (BOUND)
   ) u_coef_check (
      .val_i    (val),
      .last_i   (last),
      .mod2_i   (mod2_q),
      .accept_o (accept)
   );

   always_comb begin
      state_d = state_q;
      u_d     = u_q;
      mod2_d  = mod2_q;
      rej_d   = rej_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;
      done_d  = 1'b0;
      case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StRun;
               u_d     = '0;
               mod2_d  = 1'b0;
               rej_d   = '0;
            end
         end
         StRun: begin
            if (val_valid) begin
               if (accept) begin
                  we_d   = 1'b1;
                  addr_d = u_q;
                  data_d = val[7:0];
                  mod2_d = mod2_q ^ val[0];
                  if (last) begin
                     state_d = StDone;
                  end else begin
                     u_d = u_q + 10'd1;
                  end
               end else if (rej_q != 16'hFFFF) begin
                  rej_d = rej_q + 16'd1;
               end
            end
         end
         StDone: begin
            // done is registered so it lands the cycle after the final write
            done_d  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         u_q     <= '0;
         mod2_q  <= 1'b0;
         rej_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         u_q     <= u_d;
         mod2_q  <= mod2_d;
         rej_q   <= rej_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         done_q  <= done_d;
      end
   end

   assign gauss_ena = (state_q == StRun);
   assign busy      = (state_q != StIdle);
   assign done      = done_q;
   assign coef_we   = we_q;
   assign coef_addr = addr_q;
   assign coef_data = data_q;
   assign rej_cnt   = rej_q;

endmodule

// File: tb/tb_poly_small_mkgauss.sv
// Directed and randomized bench for poly_small_mkgauss (LOGN=2) against a
// sample-level reference model of the acceptance rules.
module tb_poly_small_mkgauss;

   localparam int LOGN  = 2;
   localparam int N     = 4;
   localparam int BOUND = 127;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        val_valid = 1'b0;
   logic [31:0] val = '0;
   logic        gauss_ena;
   logic        coef_we;
   logic [9:0]  coef_addr;
   logic [7:0]  coef_data;
   logic        busy;
   logic        done;
   logic [15:0] rej_cnt;

   poly_small_mkgauss #(
      .LOGN  (LOGN),
      .BOUND (BOUND)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .gauss_ena (gauss_ena),
      .val_valid (val_valid),
      .val       (val),
      .coef_we   (coef_we),
      .coef_addr (coef_addr),
      .coef_data (coef_data),
      .busy      (busy),
      .done      (done),
      .rej_cnt   (rej_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: run in progress, cycles left until idle after the final
   // accept, next index, running coefficient sum, reject count, expected write.
   bit       m_active = 1'b0;
   int       m_tail   = 0;
   int       m_u      = 0;
   int       m_sum    = 0;
   int       m_rej    = 0;
   bit       p_we     = 1'b0;
   int       p_addr   = 0;
   logic [7:0] p_data = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_sample(input int v);
      if (v > BOUND || v < -BOUND || (m_u == N - 1 && ((m_sum + v) % 2) == 0)) begin
         if (m_rej < 65535) m_rej++;
      end else begin
         p_we   = 1'b1;
         p_addr = m_u;
         p_data = v[7:0];
         m_sum += v;
         m_u++;
         if (m_u == N) begin
            m_active = 1'b0;
            m_tail   = 2;
         end
      end
   endtask

   // One clock: check outputs from the previous edge, then drive inputs for the next.
   task automatic step(input bit s, input bit vv, input int v, input bit r);
      bit was;
      @(negedge clk);
      chk("gauss_ena", 32'(gauss_ena), 32'(m_active));
      chk("busy", 32'(busy), 32'(m_active || m_tail == 2));
      chk("done", 32'(done), 32'(m_tail == 1));
      chk("rej_cnt", 32'(rej_cnt), 32'(m_rej));
      chk("coef_we", 32'(coef_we), 32'(p_we));
      if (p_we) begin
         chk("coef_addr", 32'(coef_addr), 32'(p_addr));
         chk("coef_data", 32'(coef_data), 32'(p_data));
      end
      p_we = 1'b0;
      if (m_tail > 0) m_tail--;
      rst       = r;
      start     = s;
      val_valid = vv;
      val       = v;
      if (r) begin
         m_active = 1'b0;
         m_tail   = 0;
         m_u      = 0;
         m_sum    = 0;
         m_rej    = 0;
      end else begin
         was = m_active;
         if (s && !m_active && m_tail == 0) begin
            m_active = 1'b1;
            m_u      = 0;
            m_sum    = 0;
            m_rej    = 0;
         end
         if (vv && was) model_sample(v);
      end
   endtask

   task automatic seq(input int q[$]);
      step(1'b1, 1'b0, 0, 1'b0);
      foreach (q[i]) step(1'b0, 1'b1, q[i], 1'b0);
      repeat (4) step(1'b0, 1'b0, 0, 1'b0);
   endtask

   initial begin
      int q[$];
      bit s, vv, r;
      int v;

      // Reset state
      step(1'b0, 1'b0, 0, 1'b1);
      step(1'b0, 1'b0, 0, 1'b0);
      chk("rst_addr", 32'(coef_addr), 32'd0);
      chk("rst_data", 32'(coef_data), 32'd0);

      // Final sample must make the coefficient sum odd, so 2 is rejected here
      q = '{3, -5, 0, 2, 1};
      seq(q);
      q = '{1, 200, -128, 1, 1, 2};
      seq(q);
      q = '{1, 1, 0, 4, 6, 3};
      seq(q);
      // Magnitude boundaries and values whose low bits alone look small
      q = '{127, -127, 128, -128, 32'h80000000, 32'h7FFFFFFF, 257, -256, 2, 1};
      seq(q);

      // Reset in the middle of a run, then a clean run from index 0
      step(1'b1, 1'b0, 0, 1'b0);
      step(1'b0, 1'b1, 5, 1'b0);
      step(1'b0, 1'b1, 7, 1'b0);
      step(1'b0, 1'b0, 0, 1'b0);
      step(1'b0, 1'b0, 0, 1'b1);
      step(1'b0, 1'b0, 0, 1'b0);
      chk("midrst_addr", 32'(coef_addr), 32'd0);
      chk("midrst_data", 32'(coef_data), 32'd0);
      q = '{-1, 4, 4, 4};
      seq(q);

      // Samples in idle and start pulses during a run are ignored
      step(1'b0, 1'b1, 9, 1'b0);
      step(1'b0, 1'b1, 9, 1'b0);
      step(1'b1, 1'b0, 0, 1'b0);
      step(1'b0, 1'b1, 1, 1'b0);
      step(1'b1, 1'b1, 2, 1'b0);
      step(1'b1, 1'b0, 0, 1'b0);
      step(1'b0, 1'b1, 3, 1'b0);
      step(1'b0, 1'b1, 1, 1'b0);
      step(1'b1, 1'b1, 9, 1'b0);
      step(1'b0, 1'b1, 9, 1'b0);
      repeat (3) step(1'b0, 1'b0, 0, 1'b0);

      // Randomized traffic with gaps, stray starts and occasional resets
      for (int run = 0; run < 12; run++) begin
         step(1'b1, 1'b0, 0, 1'b0);
         for (int k = 0; k < 30; k++) begin
            vv = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 4) == 0) v = int'($urandom);
            else v = int'($urandom_range(0, 300)) - 150;
            s = ($urandom_range(0, 9) == 0);
            r = ($urandom_range(0, 59) == 0);
            step(s, vv, v, r);
         end
         repeat (3) step(1'b0, 1'b0, 0, 1'b0);
      end

      step(1'b0, 1'b0, 0, 1'b0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
